// File: rtl/mvm_stream_engine.sv
// mvm_stream_engine: ROM-fed P-lane signed matrix-vector MAC with valid/ready output; `define MVM_STREAM_RELU_EN clamps negative results to 0
module mvm_stream_engine #(
    parameter int DW = 8,
    parameter int N = 4,
    parameter int P = 2,
    parameter int AW = 8,
    parameter int ROWS = 3,
    parameter int VEC_ADDR = 0,
    parameter int MAT_BASE = 1,
    localparam int ACC_W = 2*DW + $clog2(N)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    output logic [AW-1:0]     rom_addr,
    input  logic [N*DW-1:0]   rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [AW-1:0]     out_idx,
    output logic              busy,
    output logic              done
);
    localparam int KN = N / P;
    localparam int KW = KN > 1 ? $clog2(KN) : 1;

    if (N % P != 0) begin : g_bad
        $error("mvm_stream_engine: N must be a multiple of P");
    end

    typedef enum logic [2:0] {IDLE, VEC_WAIT, VEC_CAP, ROW_WAIT, ROW_CAP, MAC, OUT, DONE} state_t;
    state_t state, state_next;

    logic [N*DW-1:0] vec_reg, row_reg;
    logic signed [ACC_W-1:0] acc, acc_next, lane_sum, res;
    logic [KW-1:0] k;
    logic [AW-1:0] r;
    logic signed [2*DW-1:0] prod [P];
    logic last_k, last_r, hs;

    for (genvar j = 0; j < P; j++) begin : g_lane
        assign prod[j] = $signed(vec_reg[(int'(k)*P+j)*DW +: DW]) * $signed(row_reg[(int'(k)*P+j)*DW +: DW]);
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < P; i++) lane_sum = lane_sum + ACC_W'(prod[i]);
    end

    assign acc_next = acc + lane_sum;
`ifdef MVM_STREAM_RELU_EN
    assign res = acc_next[ACC_W-1] ? '0 : acc_next;
`else
    assign res = acc_next;
`endif
    assign last_k = k == KW'(KN-1);
    assign last_r = r == AW'(ROWS-1);
    assign hs = out_valid & out_ready;
    assign busy = !(state == IDLE || state == DONE);
    assign done = state == DONE;

    always_ff @(posedge clk1) state <= rst ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? VEC_WAIT : state;
            VEC_WAIT:   state_next = VEC_CAP;
            VEC_CAP:    state_next = ROW_WAIT;
            ROW_WAIT:   state_next = ROW_CAP;
            ROW_CAP:    state_next = MAC;
            MAC:        state_next = last_k ? OUT : MAC;
            OUT:        state_next = hs ? (last_r ? DONE : ROW_WAIT) : OUT;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            rom_addr <= '0;
            vec_reg <= '0;
            row_reg <= '0;
            acc <= '0;
            k <= '0;
            r <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    rom_addr <= AW'(VEC_ADDR);
                    r <= '0;
                end
                VEC_CAP: begin
                    vec_reg <= rom_data;
                    rom_addr <= AW'(MAT_BASE) + r;
                end
                ROW_CAP: begin
                    row_reg <= rom_data;
                    acc <= '0;
                    k <= '0;
                end
                MAC: begin
                    acc <= acc_next;
                    k <= k + KW'(1);
                    if (last_k) begin
                        out_data <= res;
                        out_idx <= r;
                        out_valid <= 1'b1;
                    end
                end
                OUT: if (hs) begin
                    out_valid <= 1'b0;
                    if (!last_r) begin
                        r <= r + AW'(1);
                        rom_addr <= AW'(MAT_BASE) + r + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_stream_engine.sv
// tb_mvm_stream_engine: table-driven runs plus backpressure, restart and mid-run reset sequences
module tb_mvm_stream_engine;
    logic clk1 = 1'b0;
    logic rst, start, out_ready, out_valid, busy, done;
    logic [7:0] rom_addr, out_idx;
    logic [31:0] rom_data;
    logic [17:0] out_data;
    logic [31:0] mem [256];
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] vec;
        logic [2:0][31:0] rows;
        logic [2:0][31:0] exp;
    } tv_t;
    tv_t tv [3];

    always #5 clk1 = ~clk1;
    always @(posedge clk1) rom_data <= mem[rom_addr];

    mvm_stream_engine dut (
        .clk1(clk1), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int relu(input int x);
`ifdef MVM_STREAM_RELU_EN
        return x < 0 ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic int expv(input int c, input int r);
        return relu(int'($signed(tv[c].exp[r])));
    endfunction

    task automatic load(input int c);
        mem[0] = tv[c].vec;
        for (int r = 0; r < 3; r++) mem[1+r] = tv[c].rows[r];
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic run_case(input int c, input bit stall, input bit busy_start);
        int n;
        load(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_low", done, 0);
        for (int r = 0; r < 3; r++) begin
            wait_valid(n);
            start = 1'b0;
            chk("latency", n, r == 0 ? 6 : 4);
            chk("out_data", int'($signed(out_data)), expv(c, r));
            chk("out_idx", int'(out_idx), r);
            chk("rom_addr", int'(rom_addr), 1 + r);
            if (stall && r == 1) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", int'($signed(out_data)), expv(c, r));
                    chk("stall_addr", int'(rom_addr), 2);
                end
                out_ready = 1'b1;
            end
            start = busy_start && r == 0;
            tick();
            chk("valid_drop", out_valid, 0);
            chk("done", done, int'(r == 2));
        end
        chk("end_busy_low", busy, 0);
    endtask

    initial begin
        int n, seen;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        tv[0].vec = 32'h04030201;
        tv[0].rows[0] = 32'h01010101; tv[0].exp[0] = 10;
        tv[0].rows[1] = 32'h000000FF; tv[0].exp[1] = -1;
        tv[0].rows[2] = 32'h0100FF02; tv[0].exp[2] = 4;
        tv[1].vec = 32'h80808080;
        tv[1].rows[0] = 32'h80808080; tv[1].exp[0] = 65536;
        tv[1].rows[1] = 32'h7F7F7F7F; tv[1].exp[1] = -65024;
        tv[1].rows[2] = 32'h807F807F; tv[1].exp[2] = 256;
        tv[2].vec = 32'hFE07FB03;
        tv[2].rows[0] = 32'h02020202; tv[2].exp[0] = 6;
        tv[2].rows[1] = 32'hFFFFFFFF; tv[2].exp[1] = -3;
        tv[2].rows[2] = 32'h05FD000A; tv[2].exp[2] = -1;

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_idx", int'(out_idx), 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 3; i++) run_case(i, i == 0, 1'b0);
        run_case(0, 1'b0, 1'b1);

        load(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        tick();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", int'(rom_addr), 0);
        seen = 0;
        repeat (12) begin
            tick();
            seen += int'(out_valid | busy);
        end
        chk("abort_quiet", seen, 0);
        run_case(0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
